// File: rtl/branch_resolve_unit.sv
// Branch resolution at the EX/MEM boundary: evaluates RV32I conditional branches, registers the
// outcome/redirect, and maintains a direct-mapped 2-bit branch history table used by fetch.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [2:0]       ex_func3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1_data,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_redirect_pc,
    output logic             res_illegal,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] ex_idx;
    logic [BHT_IDX_W-1:0] if_idx;
    logic                 taken_c;
    logic                 illegal_c;
    logic                 mispredict_c;
    logic                 capture;
    logic                 legal_upd;
    logic [XLEN-1:0]      redirect_c;
    logic                 unused_if_bits;

    assign ex_idx         = ex_pc[BHT_IDX_W+1:2];
    assign if_idx         = if_pc[BHT_IDX_W+1:2];
    assign unused_if_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    // No bypass: a same-cycle update to this index is only visible from the next cycle.
    assign if_pred_taken = bht[if_idx][1];

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (ex_func3)
            3'b000:  taken_c = (ex_rs1_data == ex_rs2_data);
            3'b001:  taken_c = (ex_rs1_data != ex_rs2_data);
            3'b100:  taken_c = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            3'b101:  taken_c = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            3'b110:  taken_c = (ex_rs1_data <  ex_rs2_data);
            3'b111:  taken_c = (ex_rs1_data >= ex_rs2_data);
            default: illegal_c = 1'b1;
        endcase
        mispredict_c = ~illegal_c & (taken_c ^ ex_pred_taken);
        redirect_c   = taken_c ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
        capture      = ex_valid & ~flush;
        legal_upd    = capture & ~illegal_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
            res_illegal     <= 1'b0;
        end else if (capture) begin
            res_valid       <= 1'b1;
            res_taken       <= taken_c;
            res_mispredict  <= mispredict_c;
            res_redirect_pc <= redirect_c;
            res_illegal     <= illegal_c;
        end else begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
            res_illegal     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt <= '0;
        end else if (legal_upd && mispredict_c && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (legal_upd) begin
            if (taken_c && (bht[ex_idx] != 2'b11)) begin
                bht[ex_idx] <= bht[ex_idx] + 2'b01;
            end else if (!taken_c && (bht[ex_idx] != 2'b00)) begin
                bht[ex_idx] <= bht[ex_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by randomized branches
// checked against a behavioural model (array-based BHT, integer mispredict counter).
module tb_branch_resolve_unit;

    localparam int XLEN      = 32;
    localparam int BHT_IDX_W = 6;
    localparam int CNT_W     = 4;
    localparam int BHT_N     = 1 << BHT_IDX_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             ex_valid;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic [XLEN-1:0]  res_redirect_pc;
    logic             res_illegal;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic [CNT_W-1:0] mispredict_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    int bht_m [BHT_N];
    int cnt_m;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_func3(ex_func3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .res_redirect_pc(res_redirect_pc),
        .res_illegal(res_illegal), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc / 4) % BHT_N;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return int'(a) <  int'(b);
            3'd5:    return int'(a) >= int'(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_N; i++) bht_m[i] = 1;
        cnt_m = 0;
    endtask

    // Applies one EX-stage cycle, checks the lookup before the edge and the registered result after it.
    task automatic do_branch(input logic v, input logic fl, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] a, input logic [31:0] b, input logic pred);
        bit cap, ill, tk, mp;
        logic [31:0] rd;
        ex_valid = v; flush = fl; ex_func3 = f3; ex_pc = pc; ex_imm = imm;
        ex_rs1_data = a; ex_rs2_data = b; ex_pred_taken = pred;
        #1;
        check("if_pred_taken", 32'(if_pred_taken), 32'(bht_m[idx_of(if_pc)] >= 2));
        cap = v && !fl;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        tk  = ref_taken(f3, a, b);
        mp  = !ill && (tk != pred);
        rd  = tk ? pc + imm : pc + 32'd4;
        @(posedge clk);
        if (cap && !ill) begin
            if (tk) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 3) ? 3 : bht_m[idx_of(pc)] + 1;
            else    bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 0) ? 0 : bht_m[idx_of(pc)] - 1;
            if (mp && cnt_m < CNT_MAX) cnt_m++;
        end
        #1;
        check("res_valid", 32'(res_valid), 32'(cap));
        if (cap) begin
            check("res_taken", 32'(res_taken), 32'(tk));
            check("res_mispredict", 32'(res_mispredict), 32'(mp));
            check("res_illegal", 32'(res_illegal), 32'(ill));
            check("res_redirect_pc", res_redirect_pc, rd);
        end
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(cnt_m));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, pc;
        int          base_cnt;

        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_func3 = '0; ex_pc = '0; ex_imm = '0;
        ex_rs1_data = '0; ex_rs2_data = '0; ex_pred_taken = 1'b0; if_pc = 32'h40;
        model_reset();
        #8;
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_redirect", res_redirect_pc, 32'd0);
        check("rst cnt", 32'(mispredict_cnt), 32'd0);
        check("rst if_pred", 32'(if_pred_taken), 32'd0);
        #4 rst_n = 1'b1;

        // Signed versus unsigned compares
        do_branch(1, 0, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        check("blt taken", 32'(res_taken), 32'd1);
        do_branch(1, 0, 3'b110, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        check("bltu taken", 32'(res_taken), 32'd0);
        do_branch(1, 0, 3'b101, 32'h208, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        check("bge taken", 32'(res_taken), 32'd0);
        do_branch(1, 0, 3'b111, 32'h20C, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        check("bgeu taken", 32'(res_taken), 32'd1);

        // Target computation
        do_branch(1, 0, 3'b000, 32'h100, 32'hFFFF_FFF8, 32'd7, 32'd7, 0);
        check("beq target", res_redirect_pc, 32'h0000_00F8);
        do_branch(1, 0, 3'b000, 32'h100, 32'hFFFF_FFF8, 32'd7, 32'd8, 0);
        check("beq fallthru", res_redirect_pc, 32'h0000_0104);
        do_branch(1, 0, 3'b000, 32'hFFFF_FFFC, 32'd8, 32'd1, 32'd1, 0);
        check("wrap target", res_redirect_pc, 32'h0000_0004);

        // BHT training at 0x40, prediction taken from the table itself
        if_pc = 32'h40;
        base_cnt = cnt_m;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("train read", 32'(if_pred_taken), (i == 0) ? 32'd0 : 32'd1);
            do_branch(1, 0, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5, if_pred_taken);
        end
        check("train cnt", 32'(mispredict_cnt), 32'(base_cnt + 1));
        check("train state", 32'(bht_m[idx_of(32'h40)]), 32'd3);
        do_branch(1, 0, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5, 1);
        do_branch(1, 0, 3'b001, 32'h40, 32'h20, 32'd5, 32'd5, 1);
        #1 check("sat then down", 32'(if_pred_taken), 32'd1);

        // Flush suppresses capture, BHT and counter update
        do_branch(1, 1, 3'b001, 32'h40, 32'h20, 32'd5, 32'd5, 1);
        #1 check("flush keeps bht", 32'(if_pred_taken), 32'd1);

        // Illegal funct3
        if_pc = 32'h80;
        do_branch(1, 0, 3'b010, 32'h80, 32'h40, 32'd1, 32'd1, 1);
        check("illegal redirect", res_redirect_pc, 32'h84);
        do_branch(1, 0, 3'b011, 32'h80, 32'h40, 32'd1, 32'd1, 1);
        #1 check("illegal no bht", 32'(if_pred_taken), 32'd0);

        // Back-to-back, reset during the third
        if_pc = 32'h40;
        do_branch(1, 0, 3'b000, 32'h300, 32'h8, 32'd2, 32'd2, 0);
        do_branch(1, 0, 3'b001, 32'h304, 32'h8, 32'd2, 32'd2, 1);
        ex_valid = 1'b1; ex_func3 = 3'b000; ex_pc = 32'h308; ex_pred_taken = 1'b0;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst res_valid", 32'(res_valid), 32'd0);
        check("midrst cnt", 32'(mispredict_cnt), 32'd0);
        check("midrst bht", 32'(if_pred_taken), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_branch(1, 0, 3'b000, 32'h30C, 32'h8, 32'd3, 32'd3, 0);
        do_branch(1, 0, 3'b110, 32'h310, 32'h8, 32'd3, 32'd4, 1);

        // Randomized traffic over a few BHT indices so entries and the counter saturate
        for (int i = 0; i < 400; i++) begin
            f3 = 3'($urandom_range(0, 7));
            pc = {$urandom_range(0, 7), 2'b00} + ($urandom_range(0, 1) ? 32'h0 : 32'h100);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom : ~a);
            if_pc = ($urandom_range(0, 1) != 0) ? pc : {$urandom_range(0, 15), 2'b00};
            do_branch(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), f3, pc,
                      $urandom, a, b, 1'($urandom_range(0, 1)));
        end
        check("cnt saturated", 32'(mispredict_cnt), 32'(CNT_MAX));

        ex_valid = 1'b0;
        @(posedge clk);
        #1 check("idle res_valid", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
